pcie_a7_pipe_rate_ctrl: RTL

- Parametrised PCLK rate-switch sequencer for the 7-series PIPE clocking path.
- Collects per-lane Gen1/Gen2 PCLK select requests, which arrive asynchronously from the GT lanes.
- Switches the shared PCLK mux only when every enabled lane agrees and the MMCM is locked, waits for the clock to settle, then acknowledges every enabled lane.
- Sits between the GT lane wrappers and the pipe_clock block, and drives that block's PCLK_SEL input.

---
 rtl/pcie_a7_pipe_rate_pkg.sv | 24 ++
 rtl/pcie_a7_pipe_sync.sv | 22 ++
 rtl/pcie_a7_pipe_rate_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pcie_a7_pipe_rate_pkg.sv
// Shared types and constants for the PIPE PCLK rate-switch sequencer.
// State codes are plain constants so legacy tooling can decode RATE_DBG_STATE.
package pcie_a7_pipe_rate_pkg;

  typedef logic [2:0] rate_state_t;

  localparam rate_state_t ST_IDLE   = 3'd0;
  localparam rate_state_t ST_AGREE  = 3'd1;
  localparam rate_state_t ST_SWITCH = 3'd2;
  localparam rate_state_t ST_SETTLE = 3'd3;
  localparam rate_state_t ST_ACK    = 3'd4;

  localparam logic SEL_GEN1 = 1'b0;
  localparam logic SEL_GEN2 = 1'b1;

  // Ceiling log2, never less than one bit so counters always have a width.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/pcie_a7_pipe_sync.sv
// Multi-bit flop-chain synchroniser with asynchronous active-low reset.
// Each bit is synchronised independently; no cross-bit coherency is implied.
module pcie_a7_pipe_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pcie_a7_pipe_rate_ctrl.sv
// PCLK Gen1/Gen2 rate-switch sequencer: waits for all enabled lanes to agree, flips the mux, settles, acks.
// Define PCIE_RATE_CTRL_DEBUG_EN to add RATE_DBG_STATE / RATE_DBG_SWITCHES / RATE_DBG_TIMEOUTS outputs.
module pcie_a7_pipe_rate_ctrl
  import pcie_a7_pipe_rate_pkg::*;
#(
  parameter int PCIE_LANE      = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 RATE_CLK,
  input  logic                 RATE_RST_N,
  input  logic [PCIE_LANE-1:0] RATE_PCLK_SEL_IN,
  input  logic [PCIE_LANE-1:0] RATE_LANE_EN,
  input  logic                 RATE_MMCM_LOCK,
  output logic                 RATE_PCLK_SEL_OUT,
  output logic [PCIE_LANE-1:0] RATE_ACK,
  output logic                 RATE_BUSY,
  output logic                 RATE_TIMEOUT
`ifdef PCIE_RATE_CTRL_DEBUG_EN
  ,
  output logic [2:0]           RATE_DBG_STATE,
  output logic [15:0]          RATE_DBG_SWITCHES,
  output logic [7:0]           RATE_DBG_TIMEOUTS
`endif
);

  localparam int TIMER_W  = clog2(TIMEOUT_CYCLES);
  localparam int SETTLE_W = clog2(SETTLE_CYCLES + 1);
  localparam logic [TIMER_W-1:0]  TIMER_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0]  TIMER_MAX   = '1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  logic [PCIE_LANE-1:0] sel_s;
  logic                 lock_s;
  rate_state_t          state;
  logic [TIMER_W-1:0]   timer;
  logic [SETTLE_W-1:0]  settle_cnt;
  logic                 target;
  logic                 mism;
  logic                 agree;

  pcie_a7_pipe_sync #(.WIDTH(PCIE_LANE), .STAGES(SYNC_STAGES)) u_sel_sync (
    .clk   (RATE_CLK),
    .rst_n (RATE_RST_N),
    .d     (RATE_PCLK_SEL_IN),
    .q     (sel_s)
  );

  pcie_a7_pipe_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (RATE_CLK),
    .rst_n (RATE_RST_N),
    .d     (RATE_MMCM_LOCK),
    .q     (lock_s)
  );

  // mism: some enabled lane wants a rate other than the current one; agree: all enabled lanes want target.
  assign target    = (RATE_PCLK_SEL_OUT == SEL_GEN1) ? SEL_GEN2 : SEL_GEN1;
  assign mism      = |(RATE_LANE_EN & (sel_s ^ {PCIE_LANE{RATE_PCLK_SEL_OUT}}));
  assign agree     = (RATE_LANE_EN != '0) &&
                     ((sel_s & RATE_LANE_EN) == (target ? RATE_LANE_EN : '0));
  assign RATE_BUSY = (state != ST_IDLE);

  always_ff @(posedge RATE_CLK or negedge RATE_RST_N) begin
    if (!RATE_RST_N) begin
      state             <= ST_IDLE;
      timer             <= '0;
      settle_cnt        <= '0;
      RATE_PCLK_SEL_OUT <= SEL_GEN1;
      RATE_ACK          <= '0;
      RATE_TIMEOUT      <= 1'b0;
    end else begin
      RATE_ACK     <= '0;
      RATE_TIMEOUT <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mism && lock_s) begin
            state <= ST_AGREE;
            timer <= '0;
          end
        end
        ST_AGREE: begin
          if (timer != TIMER_MAX) timer <= timer + TIMER_W'(1);
          if (!lock_s || !mism) begin
            state <= ST_IDLE;
          end else if (agree) begin
            state <= ST_SWITCH;
          end else if (timer == TIMER_LAST) begin
            RATE_TIMEOUT <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        ST_SWITCH: begin
          RATE_PCLK_SEL_OUT <= target;
          settle_cnt        <= '0;
          state             <= ST_SETTLE;
        end
        // Losing lock restarts the settle window rather than pausing it.
        ST_SETTLE: begin
          if (!lock_s)                         settle_cnt <= '0;
          else if (settle_cnt == SETTLE_LAST) state      <= ST_ACK;
          else                                 settle_cnt <= settle_cnt + SETTLE_W'(1);
        end
        ST_ACK: begin
          RATE_ACK <= RATE_LANE_EN;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PCIE_RATE_CTRL_DEBUG_EN
  assign RATE_DBG_STATE = state;

  always_ff @(posedge RATE_CLK or negedge RATE_RST_N) begin
    if (!RATE_RST_N) begin
      RATE_DBG_SWITCHES <= '0;
      RATE_DBG_TIMEOUTS <= '0;
    end else begin
      if (state == ST_ACK && RATE_DBG_SWITCHES != 16'hFFFF)
        RATE_DBG_SWITCHES <= RATE_DBG_SWITCHES + 16'd1;
      if (RATE_TIMEOUT && RATE_DBG_TIMEOUTS != 8'hFF)
        RATE_DBG_TIMEOUTS <= RATE_DBG_TIMEOUTS + 8'd1;
    end
  end
`endif

endmodule
